// File: rtl/usr_serial_deserializer_if.sv
// Bus bundle between the serial deserializer and its producer/consumer.
// The DUT takes the slave modport; the driving side takes the master modport.
interface usr_serial_deserializer_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       s;
    logic             sin;
    logic             sin_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] p;
    logic             p_valid;
    logic             p_ready;
    logic             overrun;
    logic             perr;

    modport slave (
        input  s, sin, sin_valid, a, p_ready,
        output p, p_valid, overrun, perr
    );

    modport master (
        output s, sin, sin_valid, a, p_ready,
        input  p, p_valid, overrun, perr
    );
endinterface

// File: rtl/usr_serial_deserializer.sv
// Rebuilds parallel words from an MSB- or LSB-first serial stream into a one-entry valid/ready buffer.
// Define USR_DESER_PARITY_EN to expect a trailing even-parity bit per frame and report it on perr.
module usr_serial_deserializer #(
    parameter int WIDTH = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    usr_serial_deserializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
`ifdef USR_DESER_PARITY_EN
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif

    typedef enum logic {IDLE, RECV} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count, count_next;
    logic [WIDTH-1:0] sr, sr_next;
    logic             dir, dir_next;
    logic [WIDTH-1:0] p_q, p_next;
    logic             p_valid_q, p_valid_next;
    logic             overrun_q, overrun_next;
    logic             perr_q, perr_next;

    logic             accept;
    logic             load;
    logic             dir_eff;
    logic             last_bit;
    logic             complete;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic             word_perr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            sr        <= '0;
            dir       <= 1'b0;
            p_q       <= '0;
            p_valid_q <= 1'b0;
            overrun_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            sr        <= sr_next;
            dir       <= dir_next;
            p_q       <= p_next;
            p_valid_q <= p_valid_next;
            overrun_q <= overrun_next;
            perr_q    <= perr_next;
        end
    end

    always_comb begin
        accept   = bus.sin_valid && !bus.s[0];
        load     = (bus.s == 2'b11);
        // Direction comes from the live mode only for the first bit of a frame.
        dir_eff  = (state == IDLE) ? bus.s[1] : dir;
        shifted  = dir_eff ? {bus.sin, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], bus.sin};
        last_bit = (count == CW'(LAST));
        complete = load || (accept && last_bit);
`ifdef USR_DESER_PARITY_EN
        word      = load ? bus.a : sr;
        word_perr = load ? 1'b0 : ((^sr) ^ bus.sin);
`else
        word      = load ? bus.a : shifted;
        word_perr = 1'b0;
`endif

        count_next   = count;
        sr_next      = sr;
        dir_next     = dir;
        p_next       = p_q;
        p_valid_next = p_valid_q;
        overrun_next = overrun_q;
        perr_next    = perr_q;

        if (load) begin
            count_next = '0;
            sr_next    = '0;
        end else if (accept) begin
            if (state == IDLE)
                dir_next = bus.s[1];
            if (last_bit) begin
                count_next = '0;
                sr_next    = '0;
            end else begin
                count_next = count + CW'(1);
                sr_next    = shifted;
            end
        end

        if (p_valid_q && bus.p_ready)
            p_valid_next = 1'b0;

        // A word lands only if the buffer is empty or draining this very cycle.
        if (complete) begin
            if (!p_valid_q || bus.p_ready) begin
                p_next       = word;
                p_valid_next = 1'b1;
                perr_next    = word_perr;
            end else begin
                overrun_next = 1'b1;
            end
        end

        state_next = (count_next == '0) ? IDLE : RECV;
    end

    always_comb begin
        bus.p       = p_q;
        bus.p_valid = p_valid_q;
        bus.overrun = overrun_q;
        bus.perr    = perr_q;
    end
endmodule

// File: tb/tb_usr_serial_deserializer.sv
// Directed self-checking bench for usr_serial_deserializer; works with or without USR_DESER_PARITY_EN.
module tb_usr_serial_deserializer;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    usr_serial_deserializer_if #(.WIDTH(8)) bus ();

    usr_serial_deserializer #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic [1:0] mode, input logic b);
        bus.s         = mode;
        bus.sin       = b;
        bus.sin_valid = 1'b1;
        step();
        bus.sin_valid = 1'b0;
        bus.s         = 2'b01;
    endtask

    // Sends a full frame; in the parity build an even-parity bit follows.
    task automatic send_word(input logic [1:0] mode, input logic [7:0] w);
        for (int i = 0; i < 8; i++)
            send_bit(mode, (mode == 2'b10) ? w[i] : w[7-i]);
`ifdef USR_DESER_PARITY_EN
        send_bit(mode, ^w);
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (bus.p !== 8'h00) begin errors++; $display("[TB] FAIL reset_p: got %h expected 00", bus.p); end
        checks++; if (bus.p_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_p_valid: got %b expected 0", bus.p_valid); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", bus.overrun); end
        checks++; if (bus.perr !== 1'b0) begin errors++; $display("[TB] FAIL reset_perr: got %b expected 0", bus.perr); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_msb_first();
        bus.p_ready = 1'b1;
        send_word(2'b00, 8'hDA);
        checks++; if (bus.p !== 8'hDA) begin errors++; $display("[TB] FAIL msb_p: got %h expected da", bus.p); end
        checks++; if (bus.p_valid !== 1'b1) begin errors++; $display("[TB] FAIL msb_p_valid: got %b expected 1", bus.p_valid); end
        step();
        checks++; if (bus.p_valid !== 1'b0) begin errors++; $display("[TB] FAIL msb_p_valid_drop: got %b expected 0", bus.p_valid); end
    endtask

    task automatic test_lsb_first();
        logic [7:0] w;
        w = 8'hF0;
        send_word(2'b10, w);
        checks++; if (bus.p !== 8'hF0) begin errors++; $display("[TB] FAIL lsb_p: got %h expected f0", bus.p); end
        checks++; if (bus.p_valid !== 1'b1) begin errors++; $display("[TB] FAIL lsb_p_valid: got %b expected 1", bus.p_valid); end
        for (int i = 0; i < 8; i++)
            send_bit((i < 3) ? 2'b10 : 2'b00, w[i]);
`ifdef USR_DESER_PARITY_EN
        send_bit(2'b00, ^w);
`endif
        checks++; if (bus.p !== 8'hF0) begin errors++; $display("[TB] FAIL lsb_latched_p: got %h expected f0", bus.p); end
        step();
    endtask

    task automatic test_hold();
        logic [7:0] w;
        w = 8'hA5;
        for (int i = 0; i < 4; i++)
            send_bit(2'b00, w[7-i]);
        for (int i = 0; i < 3; i++) begin
            bus.s         = 2'b01;
            bus.sin       = 1'($urandom_range(0, 1));
            bus.sin_valid = 1'b1;
            step();
        end
        bus.sin_valid = 1'b0;
        checks++; if (bus.p_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_no_word: got %b expected 0", bus.p_valid); end
        for (int i = 4; i < 8; i++)
            send_bit(2'b00, w[7-i]);
`ifdef USR_DESER_PARITY_EN
        send_bit(2'b00, ^w);
`endif
        checks++; if (bus.p !== 8'hA5) begin errors++; $display("[TB] FAIL hold_p: got %h expected a5", bus.p); end
        checks++; if (bus.p_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_p_valid: got %b expected 1", bus.p_valid); end
        step();
    endtask

    task automatic test_load_abort();
        for (int i = 0; i < 3; i++)
            send_bit(2'b00, 1'b1);
        bus.s = 2'b11;
        bus.a = 8'h3C;
        step();
        bus.s = 2'b01;
        checks++; if (bus.p !== 8'h3C) begin errors++; $display("[TB] FAIL load_p: got %h expected 3c", bus.p); end
        checks++; if (bus.p_valid !== 1'b1) begin errors++; $display("[TB] FAIL load_p_valid: got %b expected 1", bus.p_valid); end
        checks++; if (bus.perr !== 1'b0) begin errors++; $display("[TB] FAIL load_perr: got %b expected 0", bus.perr); end
        send_word(2'b00, 8'h81);
        checks++; if (bus.p !== 8'h81) begin errors++; $display("[TB] FAIL load_next_frame_p: got %h expected 81", bus.p); end
        step();
    endtask

    task automatic test_back_to_back();
        bus.p_ready = 1'b1;
        bus.s       = 2'b11;
        bus.a       = 8'h11;
        step();
        checks++; if (bus.p !== 8'h11) begin errors++; $display("[TB] FAIL b2b_first_p: got %h expected 11", bus.p); end
        bus.a = 8'h22;
        step();
        bus.s = 2'b01;
        checks++; if (bus.p !== 8'h22) begin errors++; $display("[TB] FAIL b2b_second_p: got %h expected 22", bus.p); end
        checks++; if (bus.p_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_p_valid: got %b expected 1", bus.p_valid); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overrun: got %b expected 0", bus.overrun); end
        step();
        checks++; if (bus.p_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got %b expected 0", bus.p_valid); end
    endtask

    task automatic test_backpressure();
        bus.p_ready = 1'b0;
        send_word(2'b00, 8'h11);
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_overrun_yet: got %b expected 0", bus.overrun); end
        send_word(2'b00, 8'h22);
        checks++; if (bus.p !== 8'h11) begin errors++; $display("[TB] FAIL bp_p_kept: got %h expected 11", bus.p); end
        checks++; if (bus.p_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_p_valid: got %b expected 1", bus.p_valid); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("[TB] FAIL bp_overrun: got %b expected 1", bus.overrun); end
        bus.p_ready = 1'b1;
        step();
        checks++; if (bus.p_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: got %b expected 0", bus.p_valid); end
        step();
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("[TB] FAIL bp_overrun_sticky: got %b expected 1", bus.overrun); end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 5; i++)
            send_bit(2'b00, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (bus.p !== 8'h00) begin errors++; $display("[TB] FAIL midrst_p: got %h expected 00", bus.p); end
        checks++; if (bus.p_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_p_valid: got %b expected 0", bus.p_valid); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("[TB] FAIL midrst_overrun: got %b expected 0", bus.overrun); end
        send_word(2'b00, 8'h5A);
        checks++; if (bus.p !== 8'h5A) begin errors++; $display("[TB] FAIL midrst_frame_p: got %h expected 5a", bus.p); end
        checks++; if (bus.perr !== 1'b0) begin errors++; $display("[TB] FAIL midrst_frame_perr: got %b expected 0", bus.perr); end
        step();
`ifdef USR_DESER_PARITY_EN
        for (int i = 0; i < 8; i++)
            send_bit(2'b00, (8'h5A >> (7 - i)) & 8'h01);
        send_bit(2'b00, 1'b1);
        checks++; if (bus.perr !== 1'b1) begin errors++; $display("[TB] FAIL parity_bad_perr: got %b expected 1", bus.perr); end
        checks++; if (bus.p !== 8'h5A) begin errors++; $display("[TB] FAIL parity_bad_p: got %h expected 5a", bus.p); end
        step();
        send_word(2'b00, 8'h5A);
        checks++; if (bus.perr !== 1'b0) begin errors++; $display("[TB] FAIL parity_good_perr: got %b expected 0", bus.perr); end
        step();
`endif
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.s         = 2'b01;
        bus.sin       = 1'b0;
        bus.sin_valid = 1'b0;
        bus.a         = 8'h00;
        bus.p_ready   = 1'b1;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_hold();
        test_load_abort();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
